// File: rtl/debug_pkg.sv
// Shared debug-unit types: trace FSM state encoding and the probe-channel map
// exported by the core top level.
package debug_pkg;

  typedef enum logic [1:0] {
    DBG_IDLE,
    DBG_ARMED,
    DBG_CAPTURE,
    DBG_DONE
  } dbg_state_t;

  localparam int unsigned PROBE_OPCODE_F   = 0;
  localparam int unsigned PROBE_PC_F       = 1;
  localparam int unsigned PROBE_INSTR_F    = 2;
  localparam int unsigned PROBE_PC_D       = 3;
  localparam int unsigned PROBE_INSTR_D    = 4;
  localparam int unsigned PROBE_RS1_D      = 5;
  localparam int unsigned PROBE_RS2_D      = 6;
  localparam int unsigned PROBE_IMM_D      = 7;
  localparam int unsigned PROBE_PC_E       = 8;
  localparam int unsigned PROBE_ALU_A_E    = 9;
  localparam int unsigned PROBE_ALU_B_E    = 10;
  localparam int unsigned PROBE_ALU_RES_E  = 11;
  localparam int unsigned PROBE_BR_TGT_E   = 12;
  localparam int unsigned PROBE_ADDR_M     = 13;
  localparam int unsigned PROBE_WDATA_M    = 14;
  localparam int unsigned PROBE_RDATA_M    = 15;
  localparam int unsigned PROBE_CTRL_M     = 16;
  localparam int unsigned PROBE_RD_W       = 17;
  localparam int unsigned PROBE_WB_DATA    = 18;

endpackage

// File: rtl/trace_fifo.sv
// Circular trace store: single write and read pointer, occupancy count, and a
// synchronous clear. Overflow is prevented by the controlling FSM.
module trace_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = wr_en && (count != CW'(DEPTH));
  assign rd_ok = rd_en && (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/debug_trace_unit.sv
// Debug observation unit: registered live probe mux plus a masked-compare
// triggered trace buffer that freezes DEPTH samples for host readout.
module debug_trace_unit
  import debug_pkg::*;
#(
  parameter int NUM_PROBES = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int SEL_W      = $clog2(NUM_PROBES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PROBES*DATA_W-1:0] probe_bus,
  input  logic [SEL_W-1:0]             DebugSel,
  output logic [DATA_W-1:0]            DebugOutput,
  input  logic [SEL_W-1:0]             trig_sel,
  input  logic [DATA_W-1:0]            trig_value,
  input  logic [DATA_W-1:0]            trig_mask,
  input  logic                         arm,
  input  logic                         trace_rd,
  output logic [DATA_W-1:0]            trace_data,
  output logic [$clog2(DEPTH):0]       trace_count,
  output logic                         armed,
  output logic                         triggered,
  output logic                         done
);

  localparam int CW = $clog2(DEPTH) + 1;

  function automatic logic [DATA_W-1:0] probe_word(
    input logic [NUM_PROBES*DATA_W-1:0] bus,
    input logic [SEL_W-1:0]             sel
  );
    int unsigned idx;
    if (32'(sel) >= NUM_PROBES) return '0;
    idx = 32'(sel) * DATA_W;
    return bus[idx +: DATA_W];
  endfunction

  dbg_state_t        state;
  dbg_state_t        next_state;
  logic [DATA_W-1:0] live_word;
  logic [DATA_W-1:0] trig_word;
  logic              match;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_clr;

  assign live_word = probe_word(probe_bus, DebugSel);
  assign trig_word = probe_word(probe_bus, trig_sel);
  assign match     = ((trig_word ^ trig_value) & trig_mask) == '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DBG_IDLE;
    else       state <= next_state;
  end

  // arm takes priority over every other event, in every state.
  always_comb begin
    next_state = state;
    fifo_wr    = 1'b0;
    fifo_rd    = 1'b0;
    fifo_clr   = 1'b0;
    if (arm) begin
      fifo_clr   = 1'b1;
      next_state = DBG_ARMED;
    end else begin
      unique case (state)
        DBG_IDLE: ;
        DBG_ARMED: begin
          if (match) begin
            fifo_wr    = 1'b1;
            next_state = DBG_CAPTURE;
          end
        end
        DBG_CAPTURE: begin
          fifo_wr = 1'b1;
          if (trace_count == CW'(DEPTH - 1)) next_state = DBG_DONE;
        end
        DBG_DONE: begin
          fifo_rd = trace_rd && (trace_count != '0);
        end
        default: next_state = DBG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      triggered   <= 1'b0;
      DebugOutput <= '0;
    end else begin
      DebugOutput <= live_word;
      if (arm)                                triggered <= 1'b0;
      else if (state == DBG_ARMED && match)   triggered <= 1'b1;
    end
  end

  trace_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr     (fifo_clr),
    .wr_en   (fifo_wr),
    .rd_en   (fifo_rd),
    .wr_data (live_word),
    .rd_data (trace_data),
    .count   (trace_count)
  );

  assign armed = (state == DBG_ARMED);
  assign done  = (state == DBG_DONE);

endmodule

// File: tb/tb_debug_trace_unit.sv
// Randomized and directed bench for debug_trace_unit against a queue-based
// reference model of the trigger/capture/readout behaviour.
module tb_debug_trace_unit;

  // Fewer probes than selector codes, so out-of-range selects are reachable.
  localparam int NP    = 24;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int SW    = $clog2(NP);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP*DW-1:0] probe_bus;
  logic [SW-1:0]    DebugSel;
  logic [DW-1:0]    DebugOutput;
  logic [SW-1:0]    trig_sel;
  logic [DW-1:0]    trig_value;
  logic [DW-1:0]    trig_mask;
  logic             arm;
  logic             trace_rd;
  logic [DW-1:0]    trace_data;
  logic [CW-1:0]    trace_count;
  logic             armed;
  logic             triggered;
  logic             done;

  always #5 clk = ~clk;

  debug_trace_unit #(
    .NUM_PROBES (NP),
    .DATA_W     (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .probe_bus   (probe_bus),
    .DebugSel    (DebugSel),
    .DebugOutput (DebugOutput),
    .trig_sel    (trig_sel),
    .trig_value  (trig_value),
    .trig_mask   (trig_mask),
    .arm         (arm),
    .trace_rd    (trace_rd),
    .trace_data  (trace_data),
    .trace_count (trace_count),
    .armed       (armed),
    .triggered   (triggered),
    .done        (done)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: captured samples held in a queue, plus phase flags.
  logic [31:0] q[$];
  bit          m_armed, m_trig, m_cap, m_done;
  logic [31:0] m_dbg;

  function automatic logic [31:0] probe(input int unsigned k);
    if (k >= NP) return 32'h0;
    return probe_bus[k*DW +: DW];
  endfunction

  task automatic set_probe(input int unsigned k, input logic [31:0] v);
    probe_bus[k*DW +: DW] = v;
  endtask

  task automatic model_clear();
    q.delete();
    m_armed = 0; m_trig = 0; m_cap = 0; m_done = 0;
    m_dbg = '0;
  endtask

  task automatic check_all();
    check("debug_output", DebugOutput, m_dbg);
    check("trace_count", 32'(trace_count), q.size());
    check("trace_data", trace_data, (q.size() > 0) ? q[0] : 32'h0);
    check("armed", 32'(armed), 32'(m_armed));
    check("triggered", 32'(triggered), 32'(m_trig));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic step();
    logic [31:0] sample;
    bit          hit;
    sample = probe(DebugSel);
    hit    = ((probe(trig_sel) ^ trig_value) & trig_mask) == 0;
    m_dbg  = sample;
    if (arm) begin
      q.delete();
      m_armed = 1; m_trig = 0; m_cap = 0; m_done = 0;
    end else if (m_armed && hit) begin
      q.push_back(sample);
      m_trig = 1; m_armed = 0; m_cap = 1;
    end else if (m_cap) begin
      q.push_back(sample);
      if (q.size() == DEPTH) begin
        m_cap = 0; m_done = 1;
      end
    end else if (m_done && trace_rd && q.size() > 0) begin
      void'(q.pop_front());
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_capture();
    trig_mask = '0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (DEPTH) begin
      set_probe(DebugSel, $urandom);
      step();
    end
  endtask

  initial begin
    reset = 1'b1; probe_bus = '0; DebugSel = '0; trig_sel = '0;
    trig_value = '0; trig_mask = '0; arm = 1'b0; trace_rd = 1'b0;
    model_clear();
    #12;
    check_all();
    hard_reset();

    // Live mux, in range and out of range
    set_probe(3, 32'hA5A5_0003);
    DebugSel = SW'(3);
    step();
    check("live_probe3", DebugOutput, 32'hA5A5_0003);
    DebugSel = SW'(30);
    step();
    check("live_out_of_range", DebugOutput, 32'h0);

    // Masked trigger on probe0, sample stream = cycle index
    DebugSel = SW'(5); trig_sel = '0;
    trig_value = 32'h63; trig_mask = 32'h7F;
    set_probe(0, 32'h0); set_probe(5, 32'h0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      set_probe(0, (c == 1) ? 32'h33 : (c == 2) ? 32'h13 : (c == 3) ? 32'h63 : 32'(c));
      set_probe(5, 32'(c));
      step();
      if (c == 2) check("armed_before_trigger", 32'(armed), 32'h1);
      if (c == 3) check("triggered_cycle3", 32'(triggered), 32'h1);
    end
    check("done_after_depth", 32'(done), 32'h1);
    check("count_full", 32'(trace_count), 32'(DEPTH));

    // Readout in order, then an ignored pop on an empty buffer
    for (int i = 0; i < DEPTH; i++) begin
      check("readout_order", trace_data, 32'(3 + i));
      trace_rd = 1'b1;
      step();
    end
    step();
    trace_rd = 1'b0;
    check("empty_count", 32'(trace_count), 32'h0);
    check("empty_data", trace_data, 32'h0);
    check("empty_done", 32'(done), 32'h1);

    // arm beats trace_rd in DONE
    run_capture();
    trace_rd = 1'b1;
    repeat (6) step();
    check("count_ten", 32'(trace_count), 32'd10);
    arm = 1'b1;
    step();
    arm = 1'b0; trace_rd = 1'b0;
    check("rearm_count", 32'(trace_count), 32'h0);
    check("rearm_armed", 32'(armed), 32'h1);
    check("rearm_triggered", 32'(triggered), 32'h0);

    // Zero mask triggers immediately; pops during capture are ignored
    trig_mask = '0;
    arm = 1'b1;
    step();
    arm = 1'b0; trace_rd = 1'b1;
    set_probe(5, 32'hDEAD_0001);
    step();
    check("mask0_triggered", 32'(triggered), 32'h1);
    check("mask0_first", trace_data, 32'hDEAD_0001);
    repeat (DEPTH - 1) begin
      set_probe(5, $urandom);
      step();
    end
    trace_rd = 1'b0;
    check("capture_ignores_rd", 32'(trace_count), 32'(DEPTH));

    // Reset in the middle of a capture
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (5) begin
      set_probe(5, $urandom);
      step();
    end
    check("count_before_reset", 32'(trace_count), 32'd5);
    hard_reset();
    step();
    check("idle_after_reset_armed", 32'(armed), 32'h0);
    check("idle_after_reset_done", 32'(done), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NP; k++) set_probe(k, $urandom);
      DebugSel   = SW'($urandom_range(0, 31));
      trig_sel   = SW'($urandom_range(0, 31));
      trig_value = $urandom;
      trig_mask  = 32'($urandom_range(0, 7));
      arm        = ($urandom_range(0, 59) == 0);
      trace_rd   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) begin
        arm = 1'b0; trace_rd = 1'b0;
        hard_reset();
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
